npu_stream_loader: RTL

Upstream sequencer that feeds the TinyNPU datapath/controller pair. It accepts a host word stream over a valid/ready handshake and replays it as the NPU's load sequence.
- Weight phase: SIZE*SIZE words, issued as w_in/w_load_val/w_load_sel.
- Input phase: SIZE words, issued as x_in/x_load_val.
- Compute phase: a one-cycle mac_val pulse, a programmable wait, then a one-cycle out_val pulse.
It converts a bursty, back-pressured host stream into the strictly one-word-per-cycle pulses the NPU expects.

---
 rtl/npu_pkg.sv | 24 ++
 rtl/npu_stream_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
//   Shared types for the TinyNPU stream loader.
//   - loader_state_e : loader FSM state encoding
//   - sel_bits()     : L = $clog2(SIZE), width of the PE select / x counter
// ---------------------------------------------------------------------------
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        MAC,
        WAIT,
        OUT,
        DONE
    } loader_state_e;

    // Number of bits needed to address one of SIZE PEs (SIZE is a power of two).
    function automatic int sel_bits(input int size);
        return $clog2(size);
    endfunction

endpackage

// File: rtl/npu_stream_loader.sv
// ---------------------------------------------------------------------------
// npu_stream_loader
//   Turns a bursty valid/ready host word stream into the TinyNPU load
//   sequence: SIZE*SIZE weight words, SIZE input words, a mac_val pulse,
//   a programmable wait, an out_val pulse, then a done pulse.
//
// Ports
//   clk, rst           clock / asynchronous active-low reset
//   start, mac_wait    frame start (sampled in IDLE) and mac->out spacing - 1
//   reuse_w            (NPU_STREAM_LOADER_W_REUSE_EN only) skip weight phase
//   busy, done         frame in flight / one-cycle completion pulse
//   in_val/in_rdy/in_data   host word handshake
//   w_in/w_load_val/w_load_sel   weight word, strobe, target PE
//   x_in/x_load_val    input vector word and strobe
//   mac_val, out_val   NPU compute / drain pulses
//
// Build option
//   NPU_STREAM_LOADER_W_REUSE_EN : adds reuse_w; when set at start the frame
//   goes straight to the input phase and the NPU keeps its current weights.
// ---------------------------------------------------------------------------
module npu_stream_loader
    import npu_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int NBITS = 8,
    parameter int WBITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WBITS-1:0]          mac_wait,
`ifdef NPU_STREAM_LOADER_W_REUSE_EN
    input  logic                      reuse_w,
`endif
    output logic                      busy,
    output logic                      done,
    input  logic                      in_val,
    output logic                      in_rdy,
    input  logic [NBITS-1:0]          in_data,
    output logic [NBITS-1:0]          x_in,
    output logic [NBITS-1:0]          w_in,
    output logic                      x_load_val,
    output logic                      w_load_val,
    output logic [$clog2(SIZE)-1:0]   w_load_sel,
    output logic                      mac_val,
    output logic                      out_val
);

    localparam int L   = sel_bits(SIZE);
    localparam int WCW = 2 * L;
    localparam logic [WCW-1:0] W_LAST = WCW'(SIZE * SIZE - 1);
    localparam logic [L-1:0]   X_LAST = L'(SIZE - 1);

    loader_state_e    state, state_nxt;
    logic [WCW-1:0]   w_cnt;
    logic [L-1:0]     x_cnt;
    logic [WBITS-1:0] wait_cnt;
    logic             accept;
    logic             skip_w;

`ifdef NPU_STREAM_LOADER_W_REUSE_EN
    assign skip_w = reuse_w;
`else
    assign skip_w = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = skip_w ? LOAD_X : LOAD_W;
            LOAD_W: if (accept && (w_cnt == W_LAST)) state_nxt = LOAD_X;
            LOAD_X: if (accept && (x_cnt == X_LAST)) state_nxt = MAC;
            MAC:    state_nxt = (wait_cnt != '0) ? WAIT : OUT;
            WAIT:   if (wait_cnt == WBITS'(1)) state_nxt = OUT;
            OUT:    state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs: handshake and busy follow the state directly.
    always_comb begin
        in_rdy = (state == LOAD_W) || (state == LOAD_X);
        busy   = (state != IDLE);
        accept = in_val && in_rdy;
    end

    // Frame counters. Terminal counts hold rather than wrap; the state
    // change on the terminal accept makes the held value irrelevant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_cnt    <= '0;
            x_cnt    <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    wait_cnt <= mac_wait;
                    w_cnt    <= '0;
                    x_cnt    <= '0;
                end
                LOAD_W: if (accept && (w_cnt != W_LAST)) w_cnt <= w_cnt + WCW'(1);
                LOAD_X: if (accept && (x_cnt != X_LAST)) x_cnt <= x_cnt + L'(1);
                WAIT:   wait_cnt <= wait_cnt - WBITS'(1);
                default: ;
            endcase
        end
    end

    // Output register. Every NPU-facing strobe goes through this one stage:
    // the last input word is accepted in the cycle the FSM enters MAC, so a
    // state-decoded mac_val would coincide with the final x_load_val. Keeping
    // all strobes one cycle behind the state keeps them mutually exclusive
    // while preserving the mac->out spacing, and done still lands the cycle
    // after out_val. Data words hold between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_in       <= '0;
            x_in       <= '0;
            w_load_sel <= '0;
            w_load_val <= 1'b0;
            x_load_val <= 1'b0;
            mac_val    <= 1'b0;
            out_val    <= 1'b0;
            done       <= 1'b0;
        end else begin
            w_load_val <= accept && (state == LOAD_W);
            x_load_val <= accept && (state == LOAD_X);
            mac_val    <= (state == MAC);
            out_val    <= (state == OUT);
            done       <= (state == DONE);
            if (accept && (state == LOAD_W)) begin
                w_in       <= in_data;
                w_load_sel <= w_cnt[WCW-1:L];
            end
            if (accept && (state == LOAD_X)) begin
                x_in <= in_data;
            end
        end
    end

endmodule
